// File: rtl/wl_pulse_decoder.sv
// Bank-aware wordline pulse driver: thresholds real row/bank inputs and drives one wordline, then a precharge window.
// Latency: wordline high 1 cycle after accept for PULSE_CYCLES, pch for PRE_CYCLES, ack in cycle PULSE_CYCLES+PRE_CYCLES+1.
// Backpressure: req is ignored while busy and is not queued; a req held through DONE is accepted at the next IDLE edge.
module wl_pulse_decoder #(
    parameter int  ROWS         = 16,
    parameter int  BANKS        = 2,
    parameter int  PULSE_CYCLES = 3,
    parameter int  PRE_CYCLES   = 2,
    parameter real VDD          = 1.5,
    parameter real VSS          = 0.0,
    parameter real VTH          = 0.8,
    localparam int AW           = $clog2(ROWS),
    localparam int BW           = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  real  row_sel  [0:AW-1],
    input  real  bank_sel [0:BW-1],
    output real  wl       [0:BANKS*ROWS-1],
    output real  pch,
    output logic busy,
    output logic ack,
    output logic err
);

    localparam int NWL  = BANKS * ROWS;
    localparam int MAXC = (PULSE_CYCLES > PRE_CYCLES) ?
                          ((PULSE_CYCLES > 1) ? PULSE_CYCLES : 1) :
                          ((PRE_CYCLES > 1) ? PRE_CYCLES : 1);
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] PRE_LOAD   = CW'((PRE_CYCLES > 0) ? PRE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_PRE   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] row_bits;
    logic [BW-1:0] bank_bits;
    logic [AW-1:0] row_q;
    logic [BW-1:0] bank_q;
    logic          addr_ok;
    logic          wl_en;
    logic          pch_en;
    int            sel_idx;

    // Analog-to-logic conversion is continuous; only the accept edge samples it.
    always_comb begin
        row_bits  = '0;
        bank_bits = '0;
        for (int i = 0; i < AW; i++) begin
            row_bits[i] = (row_sel[i] >= VTH);
        end
        if (BANKS > 1) begin
            for (int i = 0; i < BW; i++) begin
                bank_bits[i] = (bank_sel[i] >= VTH);
            end
        end
    end

    assign addr_ok = (int'(row_bits) < ROWS) && (int'(bank_bits) < BANKS);
    assign sel_idx = int'(bank_q) * ROWS + int'(row_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            row_q  <= '0;
            bank_q <= '0;
            wl_en  <= 1'b0;
            pch_en <= 1'b0;
            busy   <= 1'b0;
            ack    <= 1'b0;
            err    <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        row_q  <= row_bits;
                        bank_q <= bank_bits;
                        busy   <= 1'b1;
                        if (addr_ok) begin
                            state <= S_PULSE;
                            cnt   <= PULSE_LOAD;
                            wl_en <= 1'b1;
                        end else begin
                            // Rejected access: no wordline, no precharge, straight to completion.
                            state <= S_DONE;
                            ack   <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        wl_en <= 1'b0;
                        if (PRE_CYCLES > 0) begin
                            state  <= S_PRE;
                            cnt    <= PRE_LOAD;
                            pch_en <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_PRE: begin
                    if (cnt == '0) begin
                        pch_en <= 1'b0;
                        state  <= S_DONE;
                        ack    <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Real-valued drivers decoded from registered enables only.
    always_comb begin
        for (int i = 0; i < NWL; i++) begin
            wl[i] = (wl_en && (sel_idx == i)) ? VDD : VSS;
        end
        pch = pch_en ? VDD : VSS;
    end

endmodule

// File: tb/tb_wl_pulse_decoder.sv
// Bench for wl_pulse_decoder: main instance (16x2, pulse 3, pre 2) plus a 12-row, no-precharge instance.
module tb_wl_pulse_decoder;

    localparam real HI = 1.5;
    localparam real LO = 0.0;

    typedef struct {
        int idx;
        bit err;
        int npulse;
        int npch;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic req0 = 1'b0;
    real  row0  [0:3];
    real  bank0 [0:0];
    real  wl0   [0:31];
    real  pch0;
    logic busy0, ack0, err0;

    logic req1 = 1'b0;
    real  row1  [0:3];
    real  bank1 [0:0];
    real  wl1   [0:23];
    real  pch1;
    logic busy1, ack1, err1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    wl_pulse_decoder #(.ROWS(16), .BANKS(2), .PULSE_CYCLES(3), .PRE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .row_sel(row0), .bank_sel(bank0),
        .wl(wl0), .pch(pch0), .busy(busy0), .ack(ack0), .err(err0)
    );

    wl_pulse_decoder #(.ROWS(12), .BANKS(2), .PULSE_CYCLES(3), .PRE_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .row_sel(row1), .bank_sel(bank1),
        .wl(wl1), .pch(pch1), .busy(busy1), .ack(ack1), .err(err1)
    );

    task automatic set_addr0(input int r, input int b);
        for (int i = 0; i < 4; i++) row0[i] = r[i] ? HI : LO;
        bank0[0] = b[0] ? HI : LO;
    endtask

    task automatic set_addr1(input int r, input int b);
        for (int i = 0; i < 4; i++) row1[i] = r[i] ? HI : LO;
        bank1[0] = b[0] ? HI : LO;
    endtask

    task automatic push_exp(input int idx, input bit e, input int np, input int npch, input int lat);
        exp_t x;
        x = '{idx, e, np, npch, lat};
        sb.push_back(x);
    endtask

    // Scoreboard monitor for dut0: accumulates each access and compares at ack.
    initial begin : monitor0
        int cur_idx, pulse_n, pch_n, lat, nhigh, hi_idx;
        exp_t e;
        cur_idx = -1; pulse_n = 0; pch_n = 0; lat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur_idx = -1; pulse_n = 0; pch_n = 0; lat = 0;
            end else begin
                nhigh = 0; hi_idx = -1;
                for (int i = 0; i < 32; i++) begin
                    if (wl0[i] == HI) begin nhigh++; hi_idx = i; end
                end
                if (busy0) begin
                    checks++;
                    if (nhigh > 1 || (nhigh == 1 && pch0 == HI)) begin
                        errors++;
                        $display("FAIL overlap: %0d wordlines high, pch=%f (required <=1 and not with pch)", nhigh, pch0);
                    end
                end
                if (busy0) lat++;
                if (nhigh == 1) begin
                    if (pulse_n == 0) cur_idx = hi_idx;
                    else if (hi_idx != cur_idx) cur_idx = -2;
                    pulse_n++;
                end
                if (pch0 == HI) pch_n++;
                if (ack0) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_ack: ack with empty scoreboard (required no ack)");
                    end else begin
                        e = sb.pop_front();
                        if (cur_idx !== e.idx || err0 !== e.err || pulse_n !== e.npulse ||
                            pch_n !== e.npch || lat !== e.lat) begin
                            errors++;
                            $display("FAIL sb_access: got idx=%0d err=%0b pulse=%0d pch=%0d lat=%0d required idx=%0d err=%0b pulse=%0d pch=%0d lat=%0d",
                                     cur_idx, err0, pulse_n, pch_n, lat, e.idx, e.err, e.npulse, e.npch, e.lat);
                        end
                    end
                    cur_idx = -1; pulse_n = 0; pch_n = 0; lat = 0;
                end
            end
        end
    end

    task automatic wait_ack0();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (ack0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout: ack0=0 after 30 cycles (required ack)");
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        set_addr0(5, 1); set_addr1(2, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 32; i++) if (wl0[i] != LO) bad++;
        for (int i = 0; i < 24; i++) if (wl1[i] != LO) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL reset_wl: %0d wordlines not VSS (required 0)", bad); end
        checks++;
        if (pch0 != LO || pch1 != LO) begin errors++; $display("FAIL reset_pch: pch0=%f pch1=%f (required 0.0)", pch0, pch1); end
        checks++;
        if ({busy0, ack0, err0, busy1, ack1, err1} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: %b (required 000000)", {busy0, ack0, err0, busy1, ack1, err1});
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy0 || ack0 || busy1 || ack1) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL idle_after_reset: %0d active cycles (required 0)", bad); end
    endtask

    task automatic test_basic();
        bit ew, ep, ea, eb;
        @(posedge clk); #1;
        set_addr0(5, 1);
        push_exp(21, 1'b0, 3, 2, 6);
        req0 = 1'b1;
        @(posedge clk); #1 req0 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            ew = (c <= 3); ep = (c == 4 || c == 5); ea = (c == 6); eb = (c <= 6);
            checks++;
            if ((wl0[21] == HI) !== ew || (pch0 == HI) !== ep || ack0 !== ea || busy0 !== eb || err0 !== 1'b0) begin
                errors++;
                $display("FAIL basic_c%0d: wl21=%f pch=%f ack=%b busy=%b err=%b required wl21=%0b pch=%0b ack=%0b busy=%0b err=0",
                         c, wl0[21], pch0, ack0, busy0, err0, ew, ep, ea, eb);
            end
        end
    endtask

    task automatic test_row0_threshold();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) row0[i] = 0.79;
        bank0[0] = 0.8;
        push_exp(16, 1'b0, 3, 2, 6);
        req0 = 1'b1;
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (wl0[16] != HI || wl0[0] != LO || wl0[31] != LO) begin
            errors++; $display("FAIL row0_threshold: wl16=%f wl0=%f wl31=%f (required 1.5 0.0 0.0)", wl0[16], wl0[0], wl0[31]);
        end
        wait_ack0();
    endtask

    task automatic test_out_of_range();
        int nh;
        @(posedge clk); #1;
        set_addr1(13, 0);
        req1 = 1'b1;
        @(posedge clk); #1 req1 = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            nh = 0;
            for (int i = 0; i < 24; i++) if (wl1[i] == HI) nh++;
            checks++;
            if (ack1 !== (c == 1) || err1 !== (c == 1) || busy1 !== (c == 1) || nh !== 0 || pch1 != LO) begin
                errors++;
                $display("FAIL oor_c%0d: ack=%b err=%b busy=%b wl_high=%0d pch=%f required ack=err=busy=%0b wl_high=0 pch=0.0",
                         c, ack1, err1, busy1, nh, pch1, (c == 1));
            end
        end
    endtask

    task automatic test_no_precharge();
        @(posedge clk); #1;
        set_addr1(11, 1);
        req1 = 1'b1;
        @(posedge clk); #1 req1 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if ((wl1[23] == HI) !== (c <= 3) || ack1 !== (c == 4) || busy1 !== (c <= 4) || err1 !== 1'b0 || pch1 != LO) begin
                errors++;
                $display("FAIL pre0_c%0d: wl23=%f ack=%b busy=%b err=%b pch=%f required wl23=%0b ack=%0b busy=%0b err=0 pch=0.0",
                         c, wl1[23], ack1, busy1, err1, pch1, (c <= 3), (c == 4), (c <= 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        set_addr0(3, 0);
        push_exp(3, 1'b0, 3, 2, 6);
        req0 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                checks++;
                if (wl0[3] != HI || wl0[9] != LO) begin
                    errors++; $display("FAIL b2b_first_c%0d: wl3=%f wl9=%f (required 1.5 0.0)", c, wl0[3], wl0[9]);
                end
            end
            if (c == 7) begin
                checks++;
                if (busy0 !== 1'b0 || wl0[3] != LO || wl0[9] != LO) begin
                    errors++; $display("FAIL b2b_idle: busy=%b wl3=%f wl9=%f (required 0 0.0 0.0)", busy0, wl0[3], wl0[9]);
                end
            end
            if (c == 8) begin
                checks++;
                if (wl0[9] != HI || wl0[3] != LO) begin
                    errors++; $display("FAIL b2b_second: wl9=%f wl3=%f (required 1.5 0.0)", wl0[9], wl0[3]);
                end
                req0 = 1'b0;
            end
            if (c == 2) begin
                set_addr0(9, 0);
                push_exp(9, 1'b0, 3, 2, 6);
            end
            if (c == 13) begin
                checks++;
                if (ack0 !== 1'b1) begin errors++; $display("FAIL b2b_ack2: ack=%b (required 1)", ack0); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        @(posedge clk); #1;
        set_addr0(7, 1);
        req0 = 1'b1;
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wl0[23] != HI) begin errors++; $display("FAIL mid_pulse_high: wl23=%f (required 1.5)", wl0[23]); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (wl0[23] != LO || busy0 !== 1'b0 || pch0 != LO) begin
            errors++; $display("FAIL mid_reset_async: wl23=%f busy=%b pch=%f (required 0.0 0 0.0)", wl0[23], busy0, pch0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack0 || busy0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL mid_reset_no_ack: %0d active cycles (required 0)", bad); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin row0[i] = LO; row1[i] = LO; end
        bank0[0] = LO; bank1[0] = LO;
        test_reset();
        test_basic();
        test_row0_threshold();
        test_out_of_range();
        test_no_precharge();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain: %0d entries left (required 0)", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wl_pulse_decoder.md
# wl_pulse_decoder

Clocked, bank-aware wordline driver for the mixed-signal SRAM array model. It takes a real-valued row address and bank select, thresholds them to logic, and latches them on a request. It then drives exactly one real-valued wordline to VDD for a programmable pulse width, followed by a bitline-precharge window. It sits between the array controller, which issues `req` and waits for `ack`, and the bitcell array rows, and replaces the purely combinational row decoder.

## Interface
Parameters:
- `ROWS`, 16: rows per bank, ≥2; need not be a power of two.
- `BANKS`, 2: number of banks, ≥1.
- `PULSE_CYCLES`, 3: wordline high time in clocks, ≥1.
- `PRE_CYCLES`, 2: precharge time in clocks, ≥0; 0 skips precharge.
- `VDD`, 1.5: logic-high output level (real).
- `VSS`, 0.0: logic-low output level (real).
- `VTH`, 0.8: input threshold (real); an input ≥ VTH reads as 1.
- Derived: `AW = $clog2(ROWS)`, `BW = (BANKS>1) ? $clog2(BANKS) : 1`.

Ports:
- `clk`  in  1  logic clock, rising-edge active.
- `rst_n`  in  1  logic reset, asynchronous, active-low.
- `req`  in  1  logic access request.
- `row_sel`  in  real [0:AW-1]  row address, index 0 = LSB.
- `bank_sel`  in  real [0:BW-1]  bank address, index 0 = LSB; ignored when BANKS=1.
- `wl`  out  real [0:BANKS*ROWS-1]  wordlines; index = bank*ROWS + row.
- `pch`  out  real  bitline precharge enable, VDD or VSS.
- `busy`  out  1  logic, high in every state except IDLE.
- `ack`  out  1  logic, one-cycle completion pulse.
- `err`  out  1  logic, qualifies `ack`; address out of range.

## Operation
- Input conversion is continuous: each real input ≥ VTH gives 1, otherwise 0. The logic values are sampled only at the accept edge.
- Decode is true binary. Address N selects row N, and row 0 is valid. All-zero inputs select row 0 of bank 0.
- FSM states: IDLE, PULSE, PRE, DONE.
  - IDLE: on a rising edge with `req`=1, latch row R and bank B.
    - If R ≥ ROWS or B ≥ BANKS, go to DONE with error.
    - Otherwise go to PULSE and load the counter with PULSE_CYCLES-1.
  - PULSE: `wl[B*ROWS+R]`=VDD and all other wordlines are VSS. Decrement the counter. At 0, go to PRE with the counter loaded to PRE_CYCLES-1, or go to DONE if PRE_CYCLES=0.
  - PRE: all `wl`=VSS and `pch`=VDD. Decrement the counter. At 0, go to DONE.
  - DONE: `ack`=1 for exactly one cycle. `err`=1 for this cycle if the access was rejected. Next state is IDLE.
- `req` is ignored while `busy`=1 and is not queued. A `req` held high through DONE is accepted again at the IDLE edge, allowing back-to-back accesses.
- At most one wordline is VDD at any instant. `wl` and `pch` are never VDD in the same cycle.
- An out-of-range access drives no wordline and no precharge.
- Counter width is `$clog2(max(PULSE_CYCLES,PRE_CYCLES,1))+1` bits.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - All `wl`=VSS, `pch`=VSS, `busy`=0, `ack`=0, `err`=0, immediately without waiting for a clock.
  - Latched addresses clear to 0.
- Reset asserted mid-PULSE or mid-PRE aborts the access with no `ack`. After release, the first accept needs a fresh `req` edge sample.
- Outputs are registered or decoded from registered state only. There is no combinational path from `row_sel`, `bank_sel` or `req` to any output.
- Latency from the accept edge:
  - Wordline goes high one cycle after accept and stays high for PULSE_CYCLES cycles.
  - `pch` is high for the next PRE_CYCLES cycles.
  - `ack` is high in cycle PULSE_CYCLES+PRE_CYCLES+1.
  - Total occupancy is PULSE_CYCLES+PRE_CYCLES+2 cycles including IDLE.
- Error access: `ack`=1 and `err`=1 in cycle 1 after accept.
- Address changes after the accept edge have no effect on the access in flight.

## Test plan
- Reset values: hold `rst_n`=0 with `req`=1 and any inputs -> all 32 `wl`=0.0, `pch`=0.0, `busy`=0, `ack`=0, `err`=0. After release, no activity without `req`.
- Basic access (ROWS=16, BANKS=2, PULSE=3, PRE=2): `row_sel`=5 as reals (1.5,0,1.5,0), `bank_sel`=1, one-cycle `req` -> `wl[21]`=1.5 in cycles 1-3, `pch`=1.5 in cycles 4-5, `ack`=1 in cycle 6 with `err`=0, `busy` high in cycles 1-6.
- Row 0 and threshold: `row_sel`=(0.79,0.79,0.79,0.79), `bank_sel`=0.8 -> `wl[16]` pulses, confirming 0.8 reads as 1, 0.79 reads as 0, and row 0 is valid.
- Out of range (ROWS=12): `row_sel`=13 -> no `wl` and no `pch` activity, `ack`=1 and `err`=1 in cycle 1.
- Held `req` with address change mid-pulse: access 1 to row 3 with `row_sel` switched to 9 during PULSE -> row 3 pulses fully, then row 9 is accepted at the IDLE edge after DONE. No overlap between the two wordlines or between `wl` and `pch`.
- Reset mid-operation: `rst_n`=0 in cycle 2 of PULSE -> `wl` drops to 0.0 asynchronously before the next edge and no `ack` occurs. PRE_CYCLES=0 variant: `ack` in cycle PULSE+1 with `pch` never high.
